// File: rtl/usb_buf_pkg.sv
// Shared definitions for the USB endpoint byte buffers (TX and RX).
package usb_buf_pkg;

    localparam int BUF_DEPTH  = 64;
    localparam int BUF_DATA_W = 8;
    localparam int BUF_OCC_W  = 7;
    localparam int BUF_PTR_W  = 6;

    typedef logic [BUF_DATA_W-1:0] buf_byte_t;

endpackage : usb_buf_pkg

// File: rtl/buf_ptr.sv
// Wrapping buffer pointer: increments on inc, wraps modulo 2**BUF_PTR_W,
// returns to 0 on a synchronous clear.
module buf_ptr
    import usb_buf_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [BUF_PTR_W-1:0] ptr
);

    logic [BUF_PTR_W-1:0] ptr_q;
    logic [BUF_PTR_W-1:0] ptr_d;

    // Next pointer: clear overrides increment; natural overflow gives the wrap.
    always_comb begin
        // NOTE: assign a default first in every always_comb so no path can infer a latch.
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : buf_ptr

// File: rtl/rx_data_buffer.sv
// RX endpoint data buffer: byte-wide circular FIFO with first-word-fall-through
// output. Occupancy is the single authority for full/empty.
// Optional: define RX_DATA_BUFFER_ERR_EN to add the sticky buffer_err output
// (overflow or underflow seen since the last clear/reset).
module rx_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int DATA_W = BUF_DATA_W
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_W-1:0]    rx_packet_data,
    input  logic                 store_rx_packet_data,
    input  logic                 get_rx_data,
    input  logic                 clear,
    output logic [BUF_OCC_W-1:0] buffer_occupancy,
    output logic [DATA_W-1:0]    rx_data
`ifdef RX_DATA_BUFFER_ERR_EN
    ,
    output logic                 buffer_err
`endif
);

    localparam logic [BUF_OCC_W-1:0] OCC_FULL = BUF_OCC_W'(DEPTH);

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DATA_W-1:0]    mem_d [DEPTH];
    logic [BUF_OCC_W-1:0] occ_q;
    logic [BUF_OCC_W-1:0] occ_d;
    logic [BUF_PTR_W-1:0] wptr;
    logic [BUF_PTR_W-1:0] rptr;
    logic                 is_empty;
    logic                 is_full;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 do_push;
    logic                 do_pop;

    // Accept/qualify strobes. At full a simultaneous pop frees the slot the
    // push lands in; at empty a pop is refused, so there is no bypass path.
    always_comb begin
        is_empty = (occ_q == '0);
        is_full  = (occ_q == OCC_FULL);
        push_ok  = store_rx_packet_data && (!is_full || get_rx_data);
        pop_ok   = get_rx_data && !is_empty;
        do_push  = push_ok && !clear;
        do_pop   = pop_ok && !clear;
    end

    buf_ptr u_wptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (do_push),
        .ptr   (wptr)
    );

    buf_ptr u_rptr (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .inc   (do_pop),
        .ptr   (rptr)
    );

    // Storage next-state: only the addressed entry changes on a push.
    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wptr] = rx_packet_data;
        end
    end

    // Occupancy next-state: +1 push only, -1 pop only, hold otherwise.
    always_comb begin
        occ_d = occ_q;
        if (clear) begin
            occ_d = '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: the array is reset here because reset must discard every stored byte;
            // clear leaves it alone and relies on the empty mask instead.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign buffer_occupancy = occ_q;
    assign rx_data          = is_empty ? '0 : mem_q[rptr];

`ifdef RX_DATA_BUFFER_ERR_EN
    logic err_q;
    logic err_d;

    // Sticky error: overflow (push refused at full) or underflow (pop at empty); clear wins.
    always_comb begin
        err_d = err_q;
        if (clear) begin
            err_d = 1'b0;
        end else if ((store_rx_packet_data && !push_ok) || (get_rx_data && is_empty)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign buffer_err = err_q;
`endif

endmodule : rx_data_buffer

// File: tb/tb_rx_data_buffer.sv
// Directed self-checking bench for rx_data_buffer.
module tb_rx_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       get_rx_data;
    logic       clear;
    logic [6:0] buffer_occupancy;
    logic [7:0] rx_data;
`ifdef RX_DATA_BUFFER_ERR_EN
    logic       buffer_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rx_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .get_rx_data          (get_rx_data),
        .clear                (clear),
        .buffer_occupancy     (buffer_occupancy),
        .rx_data              (rx_data)
`ifdef RX_DATA_BUFFER_ERR_EN
        ,
        .buffer_err           (buffer_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = b;
        step();
        store_rx_packet_data = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        get_rx_data = 1'b1;
        step();
        get_rx_data = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        n_rst                = 1'b0;
        rx_packet_data       = '0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        clear                = 1'b0;
        #12;
        check("reset_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
`ifdef RX_DATA_BUFFER_ERR_EN
        check("reset_err", {31'd0, buffer_err}, 32'd0);
`endif
        n_rst = 1'b1;
        step();

        // Single push: occupancy and head update on the push edge.
        push_byte(8'hA5);
        check("push1_occ", {25'd0, buffer_occupancy}, 32'd1);
        check("push1_rx_data", {24'd0, rx_data}, 32'hA5);
        pop_check("pop1_data", 8'hA5);
        check("pop1_occ", {25'd0, buffer_occupancy}, 32'd0);

        // Fill to full, then overflow with 0xFF.
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        check("full_occ", {25'd0, buffer_occupancy}, 32'd64);
        push_byte(8'hFF);
        check("overflow_occ", {25'd0, buffer_occupancy}, 32'd64);
`ifdef RX_DATA_BUFFER_ERR_EN
        check("overflow_err", {31'd0, buffer_err}, 32'd1);
`endif
        for (int i = 0; i < 64; i++) pop_check("drain_data", 8'(i));
        check("drain_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("drain_rx_data", {24'd0, rx_data}, 32'd0);
        do_clear();
`ifdef RX_DATA_BUFFER_ERR_EN
        check("clear_err", {31'd0, buffer_err}, 32'd0);
`endif

        // Simultaneous push and pop at full.
        for (int i = 0; i < 64; i++) push_byte(8'(i));
        check("full2_rx_data", {24'd0, rx_data}, 32'h00);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h80;
        get_rx_data          = 1'b1;
        step();
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        check("full_pushpop_occ", {25'd0, buffer_occupancy}, 32'd64);
        for (int i = 1; i < 64; i++) pop_check("full_pushpop_data", 8'(i));
        check("full_pushpop_tail", {24'd0, rx_data}, 32'h80);
        check("full_pushpop_occ1", {25'd0, buffer_occupancy}, 32'd1);
`ifdef RX_DATA_BUFFER_ERR_EN
        check("full_pushpop_err", {31'd0, buffer_err}, 32'd0);
`endif
        pop_check("full_pushpop_last", 8'h80);

        // Pointer wrap from a clean start.
        do_clear();
        for (int i = 0; i < 40; i++) push_byte(8'(i));
        for (int i = 0; i < 40; i++) pop_check("wrap_a", 8'(i));
        for (int i = 0; i < 40; i++) push_byte(8'(8'h40 + i));
        check("wrap_occ40", {25'd0, buffer_occupancy}, 32'd40);
        for (int i = 0; i < 40; i++) pop_check("wrap_b", 8'(8'h40 + i));
        check("wrap_occ0", {25'd0, buffer_occupancy}, 32'd0);
        check("wrap_rx_data", {24'd0, rx_data}, 32'd0);

        // Push and pop together while empty: push only, no bypass.
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h3C;
        get_rx_data          = 1'b1;
        check("empty_pushpop_rx_pre", {24'd0, rx_data}, 32'd0);
        step();
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        check("empty_pushpop_occ", {25'd0, buffer_occupancy}, 32'd1);
        check("empty_pushpop_rx", {24'd0, rx_data}, 32'h3C);
        do_clear();
        get_rx_data = 1'b1;
        step();
        get_rx_data = 1'b0;
        check("underflow_occ", {25'd0, buffer_occupancy}, 32'd0);
`ifdef RX_DATA_BUFFER_ERR_EN
        check("underflow_err", {31'd0, buffer_err}, 32'd1);
`endif

        // Clear beats push and pop; pointers restart at 0.
        for (int i = 0; i < 10; i++) push_byte(8'(8'hC0 + i));
        check("pre_clear_occ", {25'd0, buffer_occupancy}, 32'd10);
        clear                = 1'b1;
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'hEE;
        get_rx_data          = 1'b1;
        step();
        clear                = 1'b0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        check("clear_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("clear_rx_data", {24'd0, rx_data}, 32'd0);
`ifdef RX_DATA_BUFFER_ERR_EN
        check("clear_err2", {31'd0, buffer_err}, 32'd0);
`endif
        push_byte(8'h11);
        check("post_clear_rx", {24'd0, rx_data}, 32'h11);
        check("post_clear_occ", {25'd0, buffer_occupancy}, 32'd1);
        push_byte(8'h22);
        pop_check("post_clear_pop0", 8'h11);
        check("post_clear_head", {24'd0, rx_data}, 32'h22);

        // Asynchronous reset mid-stream, checked before the next edge.
        push_byte(8'h33);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_occ", {25'd0, buffer_occupancy}, 32'd0);
        check("async_rst_rx", {24'd0, rx_data}, 32'd0);
        #10;
        n_rst = 1'b1;
        step();
        check("post_rst_occ", {25'd0, buffer_occupancy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rx_data_buffer
